// File: rtl/seq_stream_checker_if.sv
// -----------------------------------------------------------------------------
// seq_stream_checker_if
// Pin bundle of the Tiny Tapeout user top of seq_stream_checker.
//   ena     : high = run, low = freeze
//   ui_in   : [0] clear, [1] display select, [7:2] unused
//   uio_in  : observed 8-bit stream
//   uio_out : bidirectional outputs (tied 0)
//   uio_oe  : bidirectional output enables (tied 0, all pins are inputs)
//   uo_out  : status display
// master = the side driving the pins (board / testbench),
// slave  = the checker.
// -----------------------------------------------------------------------------
interface seq_stream_checker_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  modport master (
    output ena, ui_in, uio_in,
    input  uio_out, uio_oe, uo_out
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uio_out, uio_oe, uo_out
  );
endinterface

// File: rtl/seq_stream_checker.sv
// -----------------------------------------------------------------------------
// seq_stream_checker
// Receive-side companion to the free-running counter source. Samples the
// stream on uio_in, checks that each sample is the previous one plus 1
// (mod 2^WIDTH), locks onto the sequence, counts mismatches while locked and
// counts 0xFF->0x00 wraps. Status is shown on uo_out.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_stream_checker_if.slave (ena, ui_in, uio_in, uio_out,
//            uio_oe, uo_out)
//
// Parameters:
//   WIDTH      : stream width (1..8)
//   LOCK_COUNT : consecutive matches in ACQUIRE needed to lock (1..15)
//   LOSS_COUNT : consecutive mismatches in LOCKED that drop lock (1..15)
//
// Build option:
//   SEQ_CHECK_RESYNC_EN : when defined, a mismatch while locked re-seeds the
//   expectation from the received sample (an offset jump costs one error and
//   lock is held). When undefined, the expectation keeps free-running, so a
//   single glitched byte costs one error and an offset jump costs LOSS_COUNT
//   errors followed by reacquisition.
// -----------------------------------------------------------------------------
module seq_stream_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_stream_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

  state_t             state_q;
  logic [WIDTH-1:0]   sample_q;
  logic [WIDTH-1:0]   exp_q;
  logic [3:0]         good_q;
  logic [3:0]         bad_q;
  logic [7:0]         err_q;
  logic [6:0]         wrap_q;

  logic               clear;
  logic               match;
  logic [WIDTH-1:0]   sample_inc;
  logic               locked;
  logic               unused_ok;

  assign clear      = bus.ui_in[0];
  assign match      = (sample_q == exp_q);
  // Natural width wrap gives the mod 2^WIDTH successor, so 0xFF->0x00 matches.
  assign sample_inc = sample_q + 1'b1;
  assign locked     = (state_q == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      sample_q <= '0;
      exp_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      err_q    <= '0;
      wrap_q   <= '0;
    end else if (bus.ena) begin
      // Input stage always advances; the compare below uses the previous
      // sample, giving the one-cycle check latency.
      sample_q <= bus.uio_in[WIDTH-1:0];

      if (clear) begin
        state_q <= SEARCH;
        good_q  <= '0;
        bad_q   <= '0;
        err_q   <= '0;
        wrap_q  <= '0;
      end else begin
        case (state_q)
          SEARCH: begin
            exp_q   <= sample_inc;
            state_q <= ACQUIRE;
          end

          ACQUIRE: begin
            // Match or not, the expectation follows the received stream;
            // mismatches here are not errors, just a restart of the count.
            exp_q <= sample_inc;
            if (match) begin
              if (good_q + 4'd1 == LOCK_CNT) begin
                state_q <= LOCKED;
                good_q  <= '0;
              end else begin
                good_q <= good_q + 4'd1;
              end
            end else begin
              good_q <= '0;
            end
          end

          LOCKED: begin
            if (match) begin
              bad_q <= '0;
              exp_q <= sample_inc;
              if (sample_q == '0 && wrap_q != 7'h7F) begin
                wrap_q <= wrap_q + 7'd1;
              end
            end else begin
              if (err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
              end
              if (bad_q + 4'd1 == LOSS_CNT) begin
                state_q <= ACQUIRE;
                good_q  <= '0;
                bad_q   <= '0;
                exp_q   <= sample_inc;
              end else begin
                bad_q <= bad_q + 4'd1;
`ifdef SEQ_CHECK_RESYNC_EN
                exp_q <= sample_inc;
`else
                exp_q <= exp_q + 1'b1;
`endif
              end
            end
          end

          default: begin
            state_q <= SEARCH;
          end
        endcase
      end
    end
  end

  assign bus.uo_out  = bus.ui_in[1] ? {locked, wrap_q} : err_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  // ui_in[7:2] are reserved pins with no function.
  assign unused_ok = ^bus.ui_in[7:2];

endmodule

// File: tb/tb_seq_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_seq_stream_checker
// Self-checking bench for seq_stream_checker: directed scenarios (lock, wrap,
// glitch, offset jump, clear, freeze, saturation, reset) followed by a
// randomized stream, all compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_seq_stream_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_stream_checker_if bus();

  seq_stream_checker #(
    .WIDTH      (8),
    .LOCK_COUNT (LOCK_N),
    .LOSS_COUNT (LOSS_N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input int got, input int want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = searching, 1 = acquiring, 2 = locked
  int m_mode, m_sample, m_exp, m_good, m_bad, m_err, m_wrap;

  task automatic model_reset();
    m_mode = 0; m_sample = 0; m_exp = 0;
    m_good = 0; m_bad = 0; m_err = 0; m_wrap = 0;
  endtask

  // One enabled clock edge: judge the held sample, then take the new one.
  task automatic model_edge(input bit en, input bit clr, input int din);
    int follow;
    bit hit;
    if (!en) return;
    follow = (m_sample + 1) % 256;
    hit    = (m_sample == m_exp);
    if (clr) begin
      m_mode = 0; m_good = 0; m_bad = 0; m_err = 0; m_wrap = 0;
    end else if (m_mode == 0) begin
      m_exp = follow;
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_exp = follow;
      if (!hit) m_good = 0;
      else if (m_good + 1 >= LOCK_N) begin m_mode = 2; m_good = 0; end
      else m_good++;
    end else begin
      if (hit) begin
        m_bad = 0;
        m_exp = follow;
        if (m_sample == 0 && m_wrap < 127) m_wrap++;
      end else begin
        if (m_err < 255) m_err++;
        m_bad++;
        if (m_bad >= LOSS_N) begin
          m_mode = 1; m_good = 0; m_bad = 0; m_exp = follow;
        end else begin
`ifdef SEQ_CHECK_RESYNC_EN
          m_exp = follow;
`else
          m_exp = (m_exp + 1) % 256;
`endif
        end
      end
    end
    m_sample = din;
  endtask

  function automatic int model_disp(input bit sel);
    return sel ? (((m_mode == 2) ? 128 : 0) + m_wrap) : m_err;
  endfunction

  // ---------------- drivers ----------------
  task automatic cycle(input bit en, input bit clr, input int din);
    bit sel;
    sel = 1'($urandom);
    bus.ena    = en;
    bus.ui_in  = {6'($urandom), sel, clr};
    bus.uio_in = 8'(din);
    @(posedge clk);
    model_edge(en, clr, din);
    #1;
    check("disp", int'(bus.uo_out), model_disp(sel));
  endtask

  task automatic peek(input string tag, input bit sel, input int want);
    bus.ui_in[0] = 1'b0;
    bus.ui_in[1] = sel;
    #1;
    check(tag, int'(bus.uo_out), want);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    peek("rst_err", 1'b0, 0);
    peek("rst_stat", 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed_run(input int first, input int last);
    for (int v = first; v <= last; v++) cycle(1'b1, 1'b0, v % 256);
  endtask

  int snap_err, snap_stat, g;

  initial begin
    bus.ena = 1'b0;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    model_reset();
    #2;
    check("uio_out", int'(bus.uio_out), 0);
    check("uio_oe", int'(bus.uio_oe), 0);
    do_reset();

    // Lock: 0x10..0x16
    feed_run(16'h10, 16'h16);
    peek("lock_state", 1'b1, 128);
    peek("lock_err", 1'b0, 0);
    $display("[TB] lock: 0x10..0x16 fed");

    // Wrap through 0xFF->0x00 while locked
    do_reset();
    feed_run(16'hF0, 16'h104);
    peek("wrap_stat", 1'b1, 128 + 1);
    peek("wrap_err", 1'b0, 0);
    $display("[TB] wrap: 0xF0..0x04 fed");

    // Glitched byte 0x55 in place of 0x22
    do_reset();
    feed_run(16'h18, 16'h21);
    cycle(1'b1, 1'b0, 8'h55);
    feed_run(16'h23, 16'h26);
`ifdef SEQ_CHECK_RESYNC_EN
    peek("glitch_err", 1'b0, 2);
`else
    peek("glitch_err", 1'b0, 1);
`endif
    peek("glitch_stat", 1'b1, 128);
    $display("[TB] glitch: 0x55 injected");

    // Offset jump 0x30 -> 0x80
    do_reset();
    feed_run(16'h28, 16'h30);
    feed_run(16'h80, 16'h89);
`ifdef SEQ_CHECK_RESYNC_EN
    peek("jump_err", 1'b0, 1);
`else
    peek("jump_err", 1'b0, 3);
`endif
    peek("jump_stat", 1'b1, 128);
    $display("[TB] offset jump: 0x30 -> 0x80");

    // Clear
    cycle(1'b1, 1'b1, 8'h8A);
    peek("clr_err", 1'b0, 0);
    peek("clr_stat", 1'b1, 0);
    $display("[TB] clear pulse");

    // Freeze: relock, then hold ena low with a changing stream
    feed_run(16'h8B, 16'h93);
    snap_err = model_disp(1'b0);
    snap_stat = model_disp(1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'($urandom), int'($urandom_range(0, 255)));
    peek("frz_err", 1'b0, snap_err);
    peek("frz_stat", 1'b1, snap_stat);
    feed_run(16'h94, 16'h96);
    peek("frz_resume", 1'b0, 0);
    $display("[TB] freeze: 10 clocks with ena low");

    // Saturation: a glitch every 4th byte, 320 times
    do_reset();
    g = 0;
    for (int i = 0; i < 8; i++) begin g = (g + 1) % 256; cycle(1'b1, 1'b0, g); end
    for (int p = 0; p < 320; p++) begin
      for (int k = 0; k < 4; k++) begin
        g = (g + 1) % 256;
        cycle(1'b1, 1'b0, (k == 3) ? ((g + 128) % 256) : g);
      end
    end
    peek("sat_err", 1'b0, 255);
    peek("sat_stat", 1'b1, model_disp(1'b1));
    $display("[TB] saturation: 320 glitches");

    // Randomized stream with glitches, jumps, clears, freezes, one reset
    do_reset();
    g = int'($urandom_range(0, 255));
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 80) begin
        g = (g + 1) % 256;
        cycle(1'b1, 1'b0, g);
      end else if (r < 86) begin
        g = (g + 1) % 256;
        cycle(1'b1, 1'b0, int'($urandom_range(0, 255)));
      end else if (r < 90) begin
        g = int'($urandom_range(0, 255));
        cycle(1'b1, 1'b0, g);
      end else if (r < 92) begin
        g = (g + 1) % 256;
        cycle(1'b1, 1'b1, g);
      end else begin
        cycle(1'b0, 1'b0, int'($urandom_range(0, 255)));
      end
      if (i == 1500) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        peek("midrst_err", 1'b0, 0);
        peek("midrst_stat", 1'b1, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    peek("rand_err", 1'b0, model_disp(1'b0));
    peek("rand_stat", 1'b1, model_disp(1'b1));
    $display("[TB] random: 3000 cycles");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
